// File: rtl/seg7_scan_decoder.sv
// ----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Recovers a two-digit decimal number (0..99) from a multiplexed 7-segment
// display bus. The display driver alternates between the units digit and the
// tens digit. A decoded value is only published after MATCH_FRAMES identical
// consecutive frames, so glitches while the display is updating are filtered
// out.
//
// Parameters
//   MATCH_FRAMES  consecutive identical frames needed before value_o updates (1..15)
//   TIMEOUT       cycles without a completed frame before stale_o asserts (2..65535)
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_ni         asynchronous active-low reset
//   seg_i[6:0]     segment lines, active-high, bit0 = a ... bit6 = g
//   led_select_i   2'b10 = units digit on seg_i, 2'b01 = tens digit on seg_i
//   value_o[6:0]   last confirmed number, held between loads
//   valid_o        one-cycle pulse whenever value_o is loaded
//   locked_o       a confirmed value is held and the input stream is healthy
//   seg_err_o      one-cycle pulse per cycle with an illegal select or pattern
//   stale_o        no complete frame has arrived within TIMEOUT cycles
// ----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int unsigned MATCH_FRAMES = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [6:0] seg_i,
    input  logic [1:0] led_select_i,
    output logic [6:0] value_o,
    output logic       valid_o,
    output logic       locked_o,
    output logic       seg_err_o,
    output logic       stale_o
);

    localparam logic [0:0] S_UNITS = 1'b0;
    localparam logic [0:0] S_TENS  = 1'b1;

    localparam int unsigned   TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    localparam logic [3:0]    MATCH_N = 4'(MATCH_FRAMES);

    // Segment codes, digit 0 in the least significant slot.
    localparam logic [69:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [6:0]    seg_q;
    logic [1:0]    sel_q;
    logic          primed_q,  primed_d;
    logic [0:0]    state_q,   state_d;
    logic [3:0]    units_q,   units_d;
    logic [6:0]    cand_q,    cand_d;
    logic [3:0]    match_q,   match_d;
    logic [TW-1:0] tmo_q,     tmo_d;
    logic [6:0]    value_q,   value_d;
    logic          valid_q,   valid_d;
    logic          locked_q,  locked_d;
    logic          seg_err_q, seg_err_d;
    logic          stale_q,   stale_d;

    // ------------------------------------------------------------------
    // Pattern decode of the registered segment copy
    // ------------------------------------------------------------------
    logic [9:0] digit_hit;
    logic       digit_legal;
    logic [3:0] digit_val;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_digit_match
            assign digit_hit[gi] = (seg_q == SEG_TABLE[gi*7 +: 7]);
        end
    endgenerate

    always_comb begin
        digit_legal = |digit_hit;
        digit_val   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (digit_hit[i]) begin
                digit_val = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly, match filter and timeout
    // ------------------------------------------------------------------
    logic       sel_units;
    logic       sel_tens;
    logic       err;
    logic       frame_done;
    logic [6:0] frame_val;

    assign sel_units = (sel_q == 2'b10);
    assign sel_tens  = (sel_q == 2'b01);

    // primed_q masks the first cycle after reset, where sel_q still holds
    // its 2'b00 reset value rather than anything sampled from the pins.
    assign err        = primed_q & (~(sel_units | sel_tens) | ~digit_legal);
    assign frame_done = primed_q & ~err & (state_q == S_TENS) & sel_tens;
    assign frame_val  = ({3'b000, digit_val} * 7'd10) + {3'b000, units_q};

    always_comb begin
        primed_d  = 1'b1;
        state_d   = state_q;
        units_d   = units_q;
        cand_d    = cand_q;
        match_d   = match_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        seg_err_d = 1'b0;
        stale_d   = stale_q;
        tmo_d     = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

        if (err) begin
            // Error takes priority over everything; partial frame dropped.
            seg_err_d = 1'b1;
            state_d   = S_UNITS;
            match_d   = 4'd0;
            locked_d  = 1'b0;
        end else if (primed_q) begin
            if (sel_units) begin
                units_d = digit_val;
                state_d = S_TENS;
            end else if (frame_done) begin
                state_d = S_UNITS;
                tmo_d   = '0;
                stale_d = 1'b0;
                if ((frame_val == cand_q) && (match_q != 4'd0)) begin
                    match_d = (match_q == 4'd15) ? match_q : match_q + 4'd1;
                end else begin
                    cand_d  = frame_val;
                    match_d = 4'd1;
                end
                // Publish only on the crossing, not on every later repeat.
                if ((match_q < MATCH_N) && (match_d == MATCH_N)) begin
                    value_d  = cand_d;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                end
            end
            // A tens digit seen in S_UNITS has no units to pair with: ignored.
        end

        if (!frame_done && (tmo_d == TMO_MAX)) begin
            stale_d  = 1'b1;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            seg_q     <= 7'd0;
            sel_q     <= 2'b00;
            primed_q  <= 1'b0;
            state_q   <= S_UNITS;
            units_q   <= 4'd0;
            cand_q    <= 7'd0;
            match_q   <= 4'd0;
            tmo_q     <= '0;
            value_q   <= 7'd0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            seg_err_q <= 1'b0;
            stale_q   <= 1'b0;
        end else begin
            seg_q     <= seg_i;
            sel_q     <= led_select_i;
            primed_q  <= primed_d;
            state_q   <= state_d;
            units_q   <= units_d;
            cand_q    <= cand_d;
            match_q   <= match_d;
            tmo_q     <= tmo_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            seg_err_q <= seg_err_d;
            stale_q   <= stale_d;
        end
    end

    assign value_o   = value_q;
    assign valid_o   = valid_q;
    assign locked_o  = locked_q;
    assign seg_err_o = seg_err_q;
    assign stale_o   = stale_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

    localparam int M   = 2;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic [1:0] sel;
    logic [6:0] value_o;
    logic       valid_o;
    logic       locked_o;
    logic       seg_err_o;
    logic       stale_o;

    seg7_scan_decoder #(
        .MATCH_FRAMES(M),
        .TIMEOUT     (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .seg_i       (seg),
        .led_select_i(sel),
        .value_o     (value_o),
        .valid_o     (valid_o),
        .locked_o    (locked_o),
        .seg_err_o   (seg_err_o),
        .stale_o     (stale_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int pat [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    // Reference model state: what the decoder should believe, in plain terms.
    bit m_primed;
    int m_seen_seg, m_seen_sel;
    bit m_have_units;
    int m_units, m_cand, m_count, m_value, m_since;
    bit m_locked, m_stale, m_valid, m_err;

    int valid_seen;
    bit locked_min;

    function automatic int decode(input int s);
        for (int i = 0; i < 10; i++) begin
            if (pat[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_primed = 0; m_seen_seg = 0; m_seen_sel = 0; m_have_units = 0;
        m_units = 0; m_cand = 0; m_count = 0; m_value = 0; m_since = 0;
        m_locked = 0; m_stale = 0; m_valid = 0; m_err = 0;
    endtask

    // One rising edge: the decoder acts on what the pins showed one edge ago.
    task automatic model_edge();
        int d, frame, prev;
        m_valid = 0; m_err = 0; frame = -1;
        if (m_primed) begin
            d = decode(m_seen_seg);
            if (!(m_seen_sel == 2 || m_seen_sel == 1) || d < 0) m_err = 1;
            else if (m_seen_sel == 2) begin m_have_units = 1; m_units = d; end
            else if (m_have_units) begin frame = d * 10 + m_units; m_have_units = 0; end
        end
        if (m_err) begin m_have_units = 0; m_count = 0; m_locked = 0; end
        if (frame >= 0) begin
            prev = m_count; m_since = 0; m_stale = 0;
            if (frame == m_cand && m_count != 0) m_count = (m_count < 15) ? m_count + 1 : 15;
            else begin m_cand = frame; m_count = 1; end
            if (prev < M && m_count == M) begin m_value = m_cand; m_valid = 1; m_locked = 1; end
        end else begin
            if (m_since < TMO) m_since++;
            if (m_since == TMO) begin m_stale = 1; m_locked = 0; end
        end
        m_primed = 1; m_seen_seg = int'(seg); m_seen_sel = int'(sel);
    endtask

    task automatic step(input logic [6:0] s, input logic [1:0] l);
        seg = s; sel = l;
        @(posedge clk);
        #1;
        model_edge();
        check("value",   value_o,   m_value);
        check("valid",   valid_o,   m_valid);
        check("locked",  locked_o,  m_locked);
        check("seg_err", seg_err_o, m_err);
        check("stale",   stale_o,   m_stale);
        if (valid_o) valid_seen++;
        if (!locked_o) locked_min = 0;
        $display("step seg=%02h sel=%b -> value=%0d valid=%b locked=%b seg_err=%b stale=%b",
                 s, l, value_o, valid_o, locked_o, seg_err_o, stale_o);
    endtask

    task automatic frame(input int n);
        step(7'(pat[n % 10]), 2'b10);
        step(7'(pat[n / 10]), 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int picks [5] = '{35, 42, 7, 99, 0};
        int r, n, reps;

        // Reset state
        rst_n = 1'b0; seg = 7'h3F; sel = 2'b10;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_value",   value_o,   0);
        check("rst_valid",   valid_o,   0);
        check("rst_locked",  locked_o,  0);
        check("rst_seg_err", seg_err_o, 0);
        check("rst_stale",   stale_o,   0);
        #3 rst_n = 1'b1;

        // Three frames of 35: one load, then silence
        valid_seen = 0;
        repeat (3) frame(35);
        step(7'(pat[5]), 2'b10);
        check("s1_valid_count", valid_seen, 1);
        check("s1_value",       value_o,    35);
        check("s1_locked",      locked_o,   1);

        // Switch to 42: needs two frames, locked never drops
        valid_seen = 0; locked_min = 1;
        repeat (2) frame(42);
        step(7'(pat[2]), 2'b10);
        check("s2_valid_count", valid_seen, 1);
        check("s2_value",       value_o,    42);
        check("s2_locked_held", locked_min, 1);

        // Blank pattern on a units slot
        step(7'h00, 2'b10);
        step(7'(pat[2]), 2'b10);
        check("s3_seg_err", seg_err_o, 1);
        check("s3_locked",  locked_o,  0);
        check("s3_value",   value_o,   42);
        valid_seen = 0;
        repeat (2) frame(42);
        step(7'(pat[2]), 2'b10);
        check("s3_relock_valid", valid_seen, 1);
        check("s3_relock",       locked_o,   1);

        // Illegal select mid-frame
        step(7'(pat[3]), 2'b10);
        step(7'(pat[1]), 2'b11);
        step(7'(pat[6]), 2'b10);
        check("s4_seg_err", seg_err_o, 1);
        valid_seen = 0;
        repeat (2) frame(61);
        step(7'(pat[1]), 2'b10);
        check("s4_valid_count", valid_seen, 1);
        check("s4_value",       value_o,    61);

        // Timeout with inputs frozen on a units digit
        frame(77);
        step(7'(pat[7]), 2'b10);
        for (int k = 1; k <= 8; k++) begin
            step(7'(pat[7]), 2'b10);
            check("s5_stale",  stale_o,  32'(k == 8));
            check("s5_locked", locked_o, 32'(k < 8));
        end
        step(7'(pat[7]), 2'b01);
        step(7'(pat[7]), 2'b10);
        check("s5_stale_clear", stale_o, 0);

        // Asynchronous reset between units and tens
        step(7'(pat[9]), 2'b10);
        rst_n = 1'b0;
        #2;
        check("s6_value",   value_o,   0);
        check("s6_valid",   valid_o,   0);
        check("s6_locked",  locked_o,  0);
        check("s6_seg_err", seg_err_o, 0);
        check("s6_stale",   stale_o,   0);
        model_reset();
        #2 rst_n = 1'b1;
        valid_seen = 0;
        frame(24);
        step(7'(pat[4]), 2'b10);
        check("s6_first_frame_no_load", valid_seen, 0);
        step(7'(pat[2]), 2'b01);
        step(7'(pat[4]), 2'b10);
        check("s6_second_frame_load", valid_seen, 1);
        check("s6_value_24",          value_o,    24);

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                step(7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)));
            end else if (r < 10) begin
                step(7'(pat[$urandom_range(0, 9)]), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00);
            end else if (r < 16) begin
                reps = $urandom_range(3, 12);
                n = $urandom_range(0, 9);
                for (int k = 0; k < reps; k++) step(7'(pat[n]), 2'b10);
            end else if (r < 20) begin
                step(7'(pat[$urandom_range(0, 9)]), 2'b01);
            end else begin
                n = (r < 30) ? $urandom_range(0, 99) : picks[$urandom_range(0, 4)];
                reps = $urandom_range(1, 3);
                for (int k = 0; k < reps; k++) frame(n);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter MATCH_FRAMES, default 2: consecutive identical frames required before value is updated; legal 1..15.
REQ-002 Parameter TIMEOUT, default 255: cycles without a completed frame before stale asserts; legal 2..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 seg  input  7  segment lines, active-high; bit0=a … bit6=g.
REQ-006 led_select  input  2  digit select: 2'b10 = units digit on seg, 2'b01 = tens digit on seg, 2'b00/2'b11 illegal.
REQ-007 value  output  7  decoded number 0..99, registered.
REQ-008 valid  output  1  one-cycle pulse on each value load.
REQ-009 locked  output  1  level; a confirmed value is held and the input stream is healthy.
REQ-010 seg_err  output  1  one-cycle pulse on an illegal select code or an undecodable segment pattern.
REQ-011 stale  output  1  level; no complete frame within TIMEOUT cycles.

Function
REQ-012 seg and led_select SHALL be registered once (seg_q, sel_q); all decoding SHALL use the registered copies.
REQ-013 Legal patterns SHALL be 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; every other pattern, including 0x00, is invalid.
REQ-014 The FSM SHALL have two states: S_UNITS (waiting for a units digit) and S_TENS (units digit held, waiting for a tens digit).
REQ-015 S_UNITS: sel_q=10 with a legal pattern stores the digit as units and moves to S_TENS; sel_q=01 with a legal pattern is ignored and the FSM stays in S_UNITS.
REQ-016 S_TENS: sel_q=10 with a legal pattern overwrites units and the FSM stays in S_TENS; sel_q=01 with a legal pattern completes a frame (frame = tens*10 + units, 7-bit) and moves to S_UNITS.
REQ-017 In any state, an illegal sel_q or a pattern that fails REQ-013 SHALL do all of the following in that cycle: pulse seg_err, discard any partial frame, clear match_cnt to 0, clear locked, and move to S_UNITS.
REQ-018 On frame completion, if frame==cand and match_cnt!=0, then match_cnt SHALL increment, saturating at 15; otherwise cand is set to frame and match_cnt is set to 1.
REQ-019 value SHALL load cand and valid SHALL pulse only on the edge where match_cnt goes from below MATCH_FRAMES to equal MATCH_FRAMES; locked SHALL set on that same edge.
REQ-020 Latency: with MATCH_FRAMES met on the current frame, value, valid and locked SHALL update on the second rising edge after the tens digit first appears on the pins.
REQ-021 value SHALL hold between loads, including through seg_err and stale.
REQ-022 A timeout counter SHALL clear on every completed frame and otherwise increment, saturating at TIMEOUT.
REQ-023 When the timeout counter reaches TIMEOUT, stale SHALL set and locked SHALL clear.
REQ-024 stale SHALL clear on the next completed frame.
REQ-025 If a seg_err condition and a frame completion would occur in the same cycle, seg_err wins and no frame is counted (the two cannot occur together by construction; the priority is fixed anyway).

Reset
REQ-026 While rst_n=0, the following SHALL be forced: value=0, valid=0, locked=0, seg_err=0, stale=0, FSM=S_UNITS, cand=0, match_cnt=0, timeout counter=0, seg_q=0, sel_q=2'b00.
REQ-027 The 2'b00 reset value of sel_q SHALL NOT raise seg_err in the first cycle after release.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame immediately, without waiting for a clock edge.

Verification
REQ-029 Stimulus: alternate units 0x6D(5) and tens 0x4F(3) every cycle for 3 frames, MATCH_FRAMES=2. Response: one valid pulse with value=35 on the second frame, locked=1, and no further valid pulses.
REQ-030 Stimulus: locked on 35, then frames of 42 (units 0x5B, tens 0x66). Response: value stays 35 for one frame, then becomes 42 with one valid pulse; locked stays 1 throughout.
REQ-031 Stimulus: seg=0x00 injected on a units slot while locked on 42. Response: seg_err pulses, locked=0, value stays 42, and relock with valid pulses after 2 clean frames.
REQ-032 Stimulus: led_select=2'b11 for one cycle mid-frame. Response: seg_err pulses, partial frame discarded, match_cnt restarts at 1.
REQ-033 Stimulus: TIMEOUT=8, inputs frozen at units only. Response: stale=1 and locked=0 at the 8th cycle after the last completed frame; stale=0 after the next complete frame.
REQ-034 Stimulus: rst_n pulled low between the units and tens cycles of a frame. Response: all outputs are 0 asynchronously, and the first post-reset frame starts matching from match_cnt=1.
